mac_sequencer: RTL and testbench
================================

# mac_sequencer

Control block that sequences one FP16 dot product through the shared combinational FP16 multiplier and FP16 adder of the MAC unit. It accepts a run length, then streams operand pairs over a valid/ready handshake and drives the multiplier with each pair. It registers the product, accumulates it through the adder, and presents the final FP16 sum on a valid/ready result port. The multiplier and adder stay outside this block; it only sequences their ports.

## Interface
- CNT_W, 8: width of run-length input and internal pair counter.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- len  in  CNT_W  number of operand pairs in the run; 0 allowed.
- in_valid  in  1  operand pair present.
- in_a, in_b  in  16  FP16 operands.
- in_ready  out  1  block accepts a pair this cycle.
- mul_a, mul_b  out  16  operands to the shared multiplier.
- mul_out  in  16  multiplier product; combinational from mul_a/mul_b.
- add_a, add_b  out  16  operands to the shared adder.
- add_sum  in  16  adder sum; combinational from add_a/add_b.
- res_valid  out  1  result available.
- result  out  16  accumulated FP16 sum.
- res_ready  in  1  result consumer ready.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, MUL, ACC, DONE.
- IDLE with start=1 and len!=0:
  - Clear acc to 0x0000.
  - Load cnt with len.
  - Go to LOAD.
- IDLE with start=1 and len==0: clear acc to 0x0000 and go to DONE.
- start is ignored in every state except IDLE.
- LOAD:
  - in_ready=1.
  - When in_valid=1, capture in_a/in_b into op_a/op_b and go to MUL.
  - When in_valid=0, stay in LOAD.
- MUL: mul_a=op_a and mul_b=op_b. Register mul_out into prod. Go to ACC.
- ACC:
  - add_a=acc and add_b=prod; register add_sum into acc.
  - Decrement cnt.
  - Go to DONE if cnt was 1, otherwise go to LOAD.
- DONE:
  - res_valid=1 and result=acc.
  - On res_ready=1, go to IDLE. res_valid drops the following cycle.
- mul_a, mul_b, add_a and add_b are register-driven. They hold their last values outside MUL and ACC.
- Arithmetic is whatever the attached multiplier and adder produce. This block does no rounding, normalisation or special-case handling, except as described under Configuration.
- in_ready=0 in every state other than LOAD. A pair offered outside LOAD is not consumed.

## Timing
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - acc, prod, op_a, op_b and cnt are all 0.
  - Outputs: in_ready=0, res_valid=0, result=0x0000, busy=0, mul_a/mul_b/add_a/add_b=0x0000.
- Reset mid-run aborts immediately. The partial sum is discarded and no result is produced.
- Per pair: the accept edge plus 2 cycles, so a new pair can be accepted 3 cycles after the previous accept.
- Latency: res_valid rises 3 cycles after the last pair is accepted.
- len==0: res_valid rises 1 cycle after start is sampled.
- Back-to-back runs: start is sampled on the cycle after the DONE handshake, so the minimum gap is 1 IDLE cycle.
- result and res_valid are stable while res_ready=0, for any duration.

## Configuration
- MAC_ZERO_SKIP_EN defined:
  - A pair accepted in LOAD where in_a[14:0]==0 or in_b[14:0]==0 (±0) skips MUL and ACC.
  - cnt decrements on the accept edge; acc is unchanged.
  - Next state is DONE if cnt was 1, otherwise LOAD. The next pair can be accepted on the following cycle.
  - mul_a/mul_b/add_a/add_b are not updated for a skipped pair.
- MAC_ZERO_SKIP_EN undefined: every pair goes through MUL and ACC, with no operand inspection.

## Test plan
- Single pair: start with len=1, then pair (0x3C00, 0x4000). Required: result=0x4000, res_valid rises 3 cycles after accept, busy=1 until the DONE handshake.
- Accumulate: len=3, three pairs of (0x3C00, 0x3C00), in_valid held high. Required: accepts are spaced 3 cycles apart, result=0x4200.
- Empty run: len=0. Required: res_valid on the next cycle, result=0x0000, in_ready never asserted.
- Backpressure and start ignore:
  - Hold res_ready=0 for 5 cycles in DONE and pulse start.
  - Required: result and res_valid held, start ignored.
  - Required: IDLE is entered only after res_ready=1.
- Zero skip: len=2, pairs (0x0000, 0x4000) then (0x3C00, 0x3C00). Required: result=0x3C00 in both builds. With MAC_ZERO_SKIP_EN, the second accept comes 1 cycle after the first; without it, 3 cycles after.
- Reset mid-run: assert rst_n=0 in MUL of the 2nd pair of a len=4 run. Required: all outputs reach their reset values immediately. A new run with len=1 and pair (0x3800, 0x4000) then gives 0x3C00.

Source files
------------

// File: rtl/mac_sequencer.sv
// Sequences one FP16 dot product through an external combinational multiplier and adder.
// Optional build macro MAC_ZERO_SKIP_EN: pairs with a +/-0 operand bypass MUL/ACC.
module mac_sequencer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             in_ready,
  output logic [15:0]      mul_a,
  output logic [15:0]      mul_b,
  input  logic [15:0]      mul_out,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_sum,
  output logic             res_valid,
  output logic [15:0]      result,
  input  logic             res_ready,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, DONE} state_t;

  state_t           state;
  logic [15:0]      acc;
  logic [15:0]      prod;
  logic [15:0]      op_a;
  logic [15:0]      op_b;
  logic [15:0]      add_a_q;
  logic [CNT_W-1:0] cnt;
  logic             zero_pair_c;
  logic             last_c;

`ifdef MAC_ZERO_SKIP_EN
  assign zero_pair_c = (in_a[14:0] == 15'd0) || (in_b[14:0] == 15'd0);
`else
  assign zero_pair_c = 1'b0;
`endif

  assign last_c = (cnt == CNT_W'(1));

  // Operand ports are driven straight from the operand/product flops so they hold between runs
  assign mul_a = op_a;
  assign mul_b = op_b;
  assign add_a = add_a_q;
  assign add_b = prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= 16'h0000;
      prod      <= 16'h0000;
      op_a      <= 16'h0000;
      op_b      <= 16'h0000;
      add_a_q   <= 16'h0000;
      cnt       <= '0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      result    <= 16'h0000;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= 16'h0000;
            busy <= 1'b1;
            if (len != '0) begin
              cnt      <= len;
              in_ready <= 1'b1;
              state    <= LOAD;
            end else begin
              result    <= 16'h0000;
              res_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (zero_pair_c) begin
              // Zero product: count the pair but leave acc and the datapath ports alone
              cnt <= cnt - CNT_W'(1);
              if (last_c) begin
                in_ready  <= 1'b0;
                result    <= acc;
                res_valid <= 1'b1;
                state     <= DONE;
              end
            end else begin
              op_a     <= in_a;
              op_b     <= in_b;
              in_ready <= 1'b0;
              state    <= MUL;
            end
          end
        end
        MUL: begin
          prod    <= mul_out;
          add_a_q <= acc;
          state   <= ACC;
        end
        ACC: begin
          acc <= add_sum;
          cnt <= cnt - CNT_W'(1);
          if (last_c) begin
            result    <= add_sum;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= LOAD;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: directed scenarios plus random runs against a real-arithmetic dot-product model.
module tb_mac_sequencer;

  localparam int unsigned CNT_W = 8;
`ifdef MAC_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             in_ready;
  logic [15:0]      mul_a;
  logic [15:0]      mul_b;
  logic [15:0]      mul_out;
  logic [15:0]      add_a;
  logic [15:0]      add_b;
  logic [15:0]      add_sum;
  logic             res_valid;
  logic [15:0]      result;
  logic             res_ready;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [15:0] ra[$];
  logic [15:0] rb[$];
  logic [15:0] tbl [8];

  mac_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .res_valid(res_valid), .result(result), .res_ready(res_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FP16 <-> real for normal/zero values that are exactly representable
  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    if (h[14:10] == 5'd0) begin
      m = real'(int'(h[9:0]));
      e = -24;
    end else begin
      m = real'(int'(h[9:0]) + 1024);
      e = int'(h[14:10]) - 25;
    end
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    int   e;
    int   mant;
    real  m;
    s = (r < 0.0);
    m = s ? -r : r;
    if (m == 0.0) return 16'h0000;
    e = 15;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    mant = int'((m - 1.0) * 1024.0);
    return {s, 5'(e), 10'(mant)};
  endfunction

  // Stand-ins for the shared MAC arithmetic units
  always_comb mul_out = r2h(h2r(mul_a) * h2r(mul_b));
  always_comb add_sum = r2h(h2r(add_a) + h2r(add_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_result"},    32'(result),    32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_mul_ab"},    {mul_a, mul_b}, 32'd0);
    check({tag, "_add_ab"},    {add_a, add_b}, 32'd0);
  endtask

  // One run over the pairs in ra/rb; d_max adds idle cycles before offers, hold delays res_ready
  task automatic run_chk(input int d_max, input int hold, input bit pulse);
    real         sum;
    int          n, p, base, d, k;
    bit          skp;
    logic [15:0] held;
    n = ra.size();
    sum = 0.0;
    start = 1'b1;
    len = CNT_W'(n);
    step();
    start = 1'b0;
    p = cyc;
    base = 1;
    check("busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      d = (d_max > 0) ? int'($urandom_range(0, d_max)) : 0;
      in_valid = 1'b0;
      repeat (d) step();
      in_valid = 1'b1;
      in_a = ra[i];
      in_b = rb[i];
      k = 0;
      while (!in_ready && k < 20) begin step(); k++; end
      if (k == 20) check("in_ready_timeout", 32'd0, 32'd1);
      step();
      check("accept_gap", 32'(cyc - p), 32'((base > d + 1) ? base : d + 1));
      skp = SKIP && ((ra[i][14:0] == 15'd0) || (rb[i][14:0] == 15'd0));
      if (!skp) check("mul_ops", {mul_a, mul_b}, {ra[i], rb[i]});
      in_valid = 1'b0;
      p = cyc;
      base = skp ? 1 : 3;
      sum += h2r(ra[i]) * h2r(rb[i]);
    end
    k = 0;
    while (!res_valid && k < 20) begin step(); k++; end
    if (k == 20) check("res_valid_timeout", 32'd0, 32'd1);
    check("res_latency", 32'(cyc - p), 32'(base - 1));
    check("result", 32'(result), 32'(r2h(sum)));
    check("busy_done", 32'(busy), 32'd1);
    check("in_ready_done", 32'(in_ready), 32'd0);
    held = result;
    res_ready = 1'b0;
    for (int j = 0; j < hold; j++) begin
      if (pulse) begin start = (j == 1); len = CNT_W'(3); end
      step();
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_result", 32'(result), 32'(held));
    end
    start = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("post_valid", 32'(res_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    tbl = '{16'h0000, 16'h8000, 16'h3800, 16'h3C00, 16'h3E00, 16'h4000, 16'h4200, 16'h4400};
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = 16'h0; in_b = 16'h0; res_ready = 1'b0;
    #12;
    chk_reset("reset");
    step();
    rst_n = 1'b1;
    step();

    // Single pair 1.0 * 2.0
    ra = '{16'h3C00}; rb = '{16'h4000};
    run_chk(0, 0, 1'b0);
    // Accumulate three 1.0*1.0 with in_valid held
    ra = '{16'h3C00, 16'h3C00, 16'h3C00}; rb = '{16'h3C00, 16'h3C00, 16'h3C00};
    run_chk(0, 0, 1'b0);
    // Empty run
    ra = {}; rb = {};
    run_chk(0, 0, 1'b0);
    // Backpressure with start pulsed in DONE
    ra = '{16'h4000, 16'h3800}; rb = '{16'h4200, 16'h3C00};
    run_chk(0, 5, 1'b1);
    // Zero operand then 1.0*1.0
    ra = '{16'h0000, 16'h3C00}; rb = '{16'h4000, 16'h3C00};
    run_chk(0, 0, 1'b0);

    // Reset in MUL of the second pair of a len=4 run
    start = 1'b1; len = CNT_W'(4);
    step();
    start = 1'b0;
    in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h3C00;
    step();
    in_valid = 1'b0;
    step();
    step();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset("midrun");
    step();
    rst_n = 1'b1;
    step();
    check("after_reset_idle", 32'(res_valid), 32'd0);
    ra = '{16'h3800}; rb = '{16'h4000};
    run_chk(0, 0, 1'b0);

    // Random runs
    for (int r = 0; r < 25; r++) begin
      int n;
      n = int'($urandom_range(0, 6));
      ra = {}; rb = {};
      for (int i = 0; i < n; i++) begin
        ra.push_back(tbl[$urandom_range(0, 7)]);
        rb.push_back(tbl[$urandom_range(0, 7)]);
      end
      run_chk(3, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
